// File: rtl/abc_cond_pkg.sv
// Shared types and default constants for the A/B/C input conditioner.
package abc_cond_pkg;

    // Per-bit debounce FSM: idle on a settled level, or counting a candidate change
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_CONFIRM = 1'b1
    } ch_state_t;

    localparam int ABC_WIDTH    = 3;
    localparam int ABC_DEBOUNCE = 16;

endpackage : abc_cond_pkg

// File: rtl/abc_input_conditioner_debounce_channel.sv
// One debounced bit: FSM, confirmation counter, clean level and edge pulses.
// toggle is the combinational "clean level flips on this edge" flag, exported so
// the parent can form its change event on the same edge clean updates.
module debounce_channel
    import abc_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = ABC_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic sync_in,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    ch_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clean_q;
    logic             rise_q;
    logic             fall_q;

    // Flip decision: the differing level survived the full confirmation window
    always_comb begin
        toggle = ena && (state_q == ST_CONFIRM) && (sync_in != clean_q) && (cnt_q == CNT_LAST);
    end

    // Debounce FSM with registered level and one-cycle edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (ena) begin
                case (state_q)
                    ST_STABLE: begin
                        if (sync_in != clean_q) begin
                            state_q <= ST_CONFIRM;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    ST_CONFIRM: begin
                        if (sync_in == clean_q) begin
                            // Glitch shorter than the window: drop it silently
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            clean_q <= ~clean_q;
                            rise_q  <= ~clean_q;
                            fall_q  <= clean_q;
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule : debounce_channel

// File: rtl/abc_input_conditioner.sv
// Front-end for the A/B/C pad inputs: synchroniser, per-bit debounce, and a
// single-entry valid/ready change-event register with sticky overflow.
module abc_input_conditioner
    import abc_cond_pkg::*;
#(
    parameter int WIDTH           = ABC_WIDTH,
    parameter int DEBOUNCE_CYCLES = ABC_DEBOUNCE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change_valid,
    output logic [WIDTH-1:0] change_data,
    input  logic             change_ready,
    output logic             overflow
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] clean_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] toggle_w;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             ovf_q;
    logic             update;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .ena    (ena),
                .sync_in(sync_q[gi]),
                .clean  (clean_w[gi]),
                .rise   (rise_w[gi]),
                .fall   (fall_w[gi]),
                .toggle (toggle_w[gi])
            );
        end
    endgenerate

    // Any bit flipping on this edge makes one event for the whole vector
    assign update = |toggle_w;

    // Synchroniser (free-running) plus event/handshake register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= raw_in;
            sync_q  <= sync1_q;
            if (update) begin
                data_q  <= clean_w ^ toggle_w;
                valid_q <= 1'b1;
                if (valid_q && !change_ready) begin
                    ovf_q <= 1'b1;
                end
            end else if (valid_q && change_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign clean_out    = clean_w;
    assign rise_pulse   = rise_w;
    assign fall_pulse   = fall_w;
    assign change_valid = valid_q;
    assign change_data  = data_q;
    assign overflow     = ovf_q;

endmodule : abc_input_conditioner

// File: tb/tb_abc_input_conditioner.sv
// Directed bench for abc_input_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_abc_input_conditioner;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [W-1:0] raw_in;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         change_valid;
    logic [W-1:0] change_data;
    logic         change_ready;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    abc_input_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .raw_in      (raw_in),
        .clean_out   (clean_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .change_valid(change_valid),
        .change_data (change_data),
        .change_ready(change_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".clean"}, 32'(clean_out), 0);
        check({tag, ".rise"},  32'(rise_pulse), 0);
        check({tag, ".fall"},  32'(fall_pulse), 0);
        check({tag, ".valid"}, 32'(change_valid), 0);
        check({tag, ".data"},  32'(change_data), 0);
        check({tag, ".ovf"},   32'(overflow), 0);
    endtask

    task automatic drain();
        change_ready = 1'b1;
        tick(1);
        check("drain.valid", 32'(change_valid), 0);
        change_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; raw_in = 3'b111; change_ready = 1'b0;
        @(negedge clk);

        // 1. reset with inputs high
        tick(1);
        check_all_zero("rst1");
        tick(1);
        check_all_zero("rst2");
        rst = 1'b0; raw_in = 3'b000;
        tick(1);
        check_all_zero("post_rst");
        tick(4);

        // 2. A rises: visible on the 6th edge, not the 5th
        raw_in = 3'b001;
        tick(5);
        check("a_rise.clean_e5", 32'(clean_out), 32'h0);
        tick(1);
        check("a_rise.clean_e6", 32'(clean_out), 32'h1);
        check("a_rise.rise",     32'(rise_pulse), 32'h1);
        check("a_rise.valid",    32'(change_valid), 1);
        check("a_rise.data",     32'(change_data), 32'h1);
        tick(1);
        check("a_rise.rise_off", 32'(rise_pulse), 32'h0);
        check("a_rise.valid_hold", 32'(change_valid), 1);
        drain();

        // 3. B glitch of 3 cycles is rejected
        raw_in = 3'b011;
        tick(3);
        raw_in = 3'b001;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("glitch.clean", 32'(clean_out), 32'h1);
            check("glitch.rise",  32'(rise_pulse), 32'h0);
            check("glitch.valid", 32'(change_valid), 0);
        end

        // A falls back, fall pulse on the 6th edge
        raw_in = 3'b000;
        tick(6);
        check("a_fall.clean", 32'(clean_out), 32'h0);
        check("a_fall.fall",  32'(fall_pulse), 32'h1);
        check("a_fall.data",  32'(change_data), 32'h0);
        drain();

        // 4. ready held low: A then B -> overwrite sets overflow
        raw_in = 3'b001;
        tick(10);
        check("ovf.first_data", 32'(change_data), 32'h1);
        check("ovf.first_ovf",  32'(overflow), 0);
        raw_in = 3'b011;
        tick(10);
        check("ovf.data",  32'(change_data), 32'h3);
        check("ovf.valid", 32'(change_valid), 1);
        check("ovf.flag",  32'(overflow), 1);
        drain();
        check("ovf.sticky", 32'(overflow), 1);
        tick(3);
        check("ovf.sticky2", 32'(overflow), 1);

        // 5a. update landing on the accepting edge keeps valid with new data
        rst = 1'b1; raw_in = 3'b000;
        tick(1);
        check("rst_mid.ovf", 32'(overflow), 0);
        rst = 1'b0;
        tick(3);
        raw_in = 3'b001;
        tick(6);
        check("same_edge.pending", 32'(change_data), 32'h1);
        raw_in = 3'b100;
        tick(5);
        change_ready = 1'b1;
        tick(1);
        change_ready = 1'b0;
        check("same_edge.valid", 32'(change_valid), 1);
        check("same_edge.data",  32'(change_data), 32'h4);
        check("same_edge.ovf",   32'(overflow), 0);
        check("same_edge.rise",  32'(rise_pulse), 32'h4);
        check("same_edge.fall",  32'(fall_pulse), 32'h1);
        drain();

        // 5b. A and B rise together -> one event
        rst = 1'b1; raw_in = 3'b000;
        tick(1);
        rst = 1'b0;
        tick(3);
        raw_in = 3'b011;
        tick(6);
        check("pair.rise",  32'(rise_pulse), 32'h3);
        check("pair.data",  32'(change_data), 32'h3);
        check("pair.valid", 32'(change_valid), 1);
        tick(1);
        check("pair.ovf",   32'(overflow), 0);
        check("pair.rise_off", 32'(rise_pulse), 32'h0);
        drain();

        // 6a. ena=0 for 5 cycles mid-CONFIRM freezes the count
        raw_in = 3'b111;
        tick(3);            // C now in CONFIRM with cnt=1
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("freeze.clean", 32'(clean_out), 32'h3);
            check("freeze.rise",  32'(rise_pulse), 32'h0);
        end
        ena = 1'b1;
        tick(2);
        check("resume.early", 32'(clean_out), 32'h3);
        tick(1);
        check("resume.clean", 32'(clean_out), 32'h7);
        check("resume.rise",  32'(rise_pulse), 32'h4);
        check("resume.data",  32'(change_data), 32'h7);
        drain();

        // 6b. reset mid-CONFIRM: no pulse, no event
        raw_in = 3'b011;
        tick(4);
        rst = 1'b1; raw_in = 3'b000;
        tick(1);
        check("rst_conf.clean", 32'(clean_out), 32'h0);
        check("rst_conf.fall",  32'(fall_pulse), 32'h0);
        check("rst_conf.valid", 32'(change_valid), 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("rst_conf.quiet_valid", 32'(change_valid), 0);
            check("rst_conf.quiet_fall",  32'(fall_pulse), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_abc_input_conditioner
